// File: rtl/bitmanip_seq.sv
// -----------------------------------------------------------------------------
// bitmanip_seq
//
// Sequencer for the bit-manipulation datapath that sits beside the ALU in
// execute. It takes one operation at a time over a valid/ready handshake and
// holds the response until the pipeline takes it.
//
// Single-cycle ops (andn, orn, xnor, min/max, orc.b, rev8, rol/ror, bset/bclr/
// binv/bext, sext/zext, shNadd) are computed in IDLE and registered straight
// into the response. clz/ctz/cpop are scanned iteratively, CHUNK_WIDTH bits
// per COUNT cycle, so the counting logic stays small.
//
// Optional feature: define BITMANIP_FASTCOUNT_EN to compute clz/ctz/cpop
// combinationally in IDLE (latency 1). COUNT is then never entered and
// CHUNK_WIDTH has no effect.
//
// Parameters:
//   CHUNK_WIDTH  bits examined per COUNT cycle (1, 2, 4, 8, 16 or 32)
//
// Ports:
//   clock         clock
//   reset         synchronous reset, active high
//   flush         abort the in-flight op; no response is produced
//   req_valid     request valid
//   req_ready     request can be accepted (IDLE and no flush)
//   req_op        operation code (24..31 are illegal)
//   req_rs1       operand 1
//   req_rs2       operand 2
//   resp_valid    result valid (held until resp_ready)
//   resp_ready    consumer accepts result
//   resp_data     result
//   resp_illegal  op code was unsupported
//   busy          sequencer is not in IDLE
// -----------------------------------------------------------------------------
module bitmanip_seq #(
   parameter int CHUNK_WIDTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_illegal,
   output logic        busy
);

   localparam int N  = 32 / CHUNK_WIDTH;
   localparam int JW = (N > 1) ? $clog2(N) : 1;

   localparam logic [4:0] OP_ANDN   = 5'd0;
   localparam logic [4:0] OP_ORN    = 5'd1;
   localparam logic [4:0] OP_XNOR   = 5'd2;
   localparam logic [4:0] OP_CLZ    = 5'd3;
   localparam logic [4:0] OP_CTZ    = 5'd4;
   localparam logic [4:0] OP_CPOP   = 5'd5;
   localparam logic [4:0] OP_MAX    = 5'd6;
   localparam logic [4:0] OP_MAXU   = 5'd7;
   localparam logic [4:0] OP_MIN    = 5'd8;
   localparam logic [4:0] OP_MINU   = 5'd9;
   localparam logic [4:0] OP_ORCB   = 5'd10;
   localparam logic [4:0] OP_REV8   = 5'd11;
   localparam logic [4:0] OP_ROL    = 5'd12;
   localparam logic [4:0] OP_ROR    = 5'd13;
   localparam logic [4:0] OP_BSET   = 5'd14;
   localparam logic [4:0] OP_BCLR   = 5'd15;
   localparam logic [4:0] OP_BINV   = 5'd16;
   localparam logic [4:0] OP_BEXT   = 5'd17;
   localparam logic [4:0] OP_SEXTB  = 5'd18;
   localparam logic [4:0] OP_SEXTH  = 5'd19;
   localparam logic [4:0] OP_ZEXTH  = 5'd20;
   localparam logic [4:0] OP_SH1ADD = 5'd21;
   localparam logic [4:0] OP_SH2ADD = 5'd22;
   localparam logic [4:0] OP_SH3ADD = 5'd23;
   localparam logic [4:0] OP_FIRST_ILLEGAL = 5'd24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                 state, state_n;
   logic [31:0]            scan, scan_n;       // operand being scanned, consumed from the LSB end
   logic [JW-1:0]          j, j_n;             // chunk index
   logic [5:0]             acc, acc_n;         // running count, max value 32
   logic                   is_cpop, is_cpop_n; // 1: cpop, 0: clz/ctz (early exit allowed)
   logic [31:0]            data_n;
   logic                   ill_n;
   logic [CHUNK_WIDTH-1:0] chunk;
   logic                   last;
   logic                   accept;

   // Zeros below the lowest set bit of a chunk (CHUNK_WIDTH if all zero).
   function automatic logic [5:0] chunk_tz(input logic [CHUNK_WIDTH-1:0] c);
      logic [5:0] r;
      r = 6'(CHUNK_WIDTH);
      for (int i = CHUNK_WIDTH - 1; i >= 0; i--)
         if (c[i]) r = 6'(i);
      return r;
   endfunction

   function automatic logic [5:0] chunk_pop(input logic [CHUNK_WIDTH-1:0] c);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < CHUNK_WIDTH; i++)
         r = r + {5'd0, c[i]};
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] a);
      logic [31:0] r;
      for (int i = 0; i < 32; i++)
         r[i] = a[31-i];
      return r;
   endfunction

`ifdef BITMANIP_FASTCOUNT_EN
   function automatic logic [5:0] clz32(input logic [31:0] a);
      logic [5:0] r;
      r = 6'd32;
      for (int i = 0; i < 32; i++)
         if (a[i]) r = 6'(31 - i);
      return r;
   endfunction

   function automatic logic [5:0] ctz32(input logic [31:0] a);
      logic [5:0] r;
      r = 6'd32;
      for (int i = 31; i >= 0; i--)
         if (a[i]) r = 6'(i);
      return r;
   endfunction

   function automatic logic [5:0] pop32(input logic [31:0] a);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         r = r + {5'd0, a[i]};
      return r;
   endfunction
`endif

   // Result of every op that completes in IDLE; count ops fall through to 0
   // unless the fast-count build handles them here.
   function automatic logic [31:0] compute(input logic [4:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic [4:0]         sh;
      logic [5:0]         rsh;
      logic [31:0]        onehot;
      logic [31:0]        r;
      sa     = a;
      sb     = b;
      sh     = b[4:0];
      rsh    = 6'd32 - {1'b0, sh};   // shift by 32 yields 0, so sh=0 rotates to a
      onehot = 32'd1 << sh;
      r      = '0;
      case (op)
         OP_ANDN:   r = a & ~b;
         OP_ORN:    r = a | ~b;
         OP_XNOR:   r = ~(a ^ b);
`ifdef BITMANIP_FASTCOUNT_EN
         OP_CLZ:    r = {26'd0, clz32(a)};
         OP_CTZ:    r = {26'd0, ctz32(a)};
         OP_CPOP:   r = {26'd0, pop32(a)};
`endif
         OP_MAX:    r = (sa > sb) ? a : b;
         OP_MAXU:   r = (a > b) ? a : b;
         OP_MIN:    r = (sa < sb) ? a : b;
         OP_MINU:   r = (a < b) ? a : b;
         OP_ORCB: begin
            for (int i = 0; i < 4; i++)
               r[8*i +: 8] = (a[8*i +: 8] != 8'd0) ? 8'hFF : 8'h00;
         end
         OP_REV8:   r = {a[7:0], a[15:8], a[23:16], a[31:24]};
         OP_ROL:    r = (a << sh) | (a >> rsh);
         OP_ROR:    r = (a >> sh) | (a << rsh);
         OP_BSET:   r = a | onehot;
         OP_BCLR:   r = a & ~onehot;
         OP_BINV:   r = a ^ onehot;
         OP_BEXT:   r = {31'd0, a[sh]};
         OP_SEXTB:  r = {{24{a[7]}}, a[7:0]};
         OP_SEXTH:  r = {{16{a[15]}}, a[15:0]};
         OP_ZEXTH:  r = {16'd0, a[15:0]};
         OP_SH1ADD: r = b + {a[30:0], 1'b0};
         OP_SH2ADD: r = b + {a[29:0], 2'b0};
         OP_SH3ADD: r = b + {a[28:0], 3'b0};
         default:   r = '0;
      endcase
      return r;
   endfunction

   assign req_ready  = (state == IDLE) & ~flush;
   assign busy       = (state != IDLE);
   assign resp_valid = (state == RESP);
   assign accept     = req_valid & req_ready;
   assign chunk      = scan[CHUNK_WIDTH-1:0];
   assign last       = (j == JW'(N - 1));

   always_comb begin
      state_n   = state;
      scan_n    = scan;
      j_n       = j;
      acc_n     = acc;
      is_cpop_n = is_cpop;
      data_n    = resp_data;
      ill_n     = resp_illegal;
      case (state)
         IDLE: begin
            if (accept) begin
               ill_n = 1'b0;
               if (req_op >= OP_FIRST_ILLEGAL) begin
                  data_n  = '0;
                  ill_n   = 1'b1;
                  state_n = RESP;
               end
`ifndef BITMANIP_FASTCOUNT_EN
               else if (req_op == OP_CLZ || req_op == OP_CTZ || req_op == OP_CPOP) begin
                  // clz becomes ctz of the bit-reversed operand, so every
                  // count op scans upward from bit 0.
                  scan_n    = (req_op == OP_CLZ) ? bitrev32(req_rs1) : req_rs1;
                  j_n       = '0;
                  acc_n     = '0;
                  is_cpop_n = (req_op == OP_CPOP);
                  state_n   = COUNT;
               end
`endif
               else begin
                  data_n  = compute(req_op, req_rs1, req_rs2);
                  state_n = RESP;
               end
            end
         end
         COUNT: begin
            j_n    = j + JW'(1);
            scan_n = scan >> CHUNK_WIDTH;
            if (is_cpop) begin
               acc_n = acc + chunk_pop(chunk);
               if (last) begin
                  data_n  = {26'd0, acc_n};
                  state_n = RESP;
               end
            end else if (chunk != '0) begin
               data_n  = {26'd0, acc + chunk_tz(chunk)};
               state_n = RESP;
            end else begin
               acc_n = acc + 6'(CHUNK_WIDTH);
               if (last) begin
                  data_n  = {26'd0, acc_n};
                  state_n = RESP;
               end
            end
         end
         RESP: begin
            if (resp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (flush) state_n = IDLE;
   end

   // Control and response registers; scan datapath carries no reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         resp_data    <= '0;
         resp_illegal <= 1'b0;
      end else begin
         state        <= state_n;
         resp_data    <= data_n;
         resp_illegal <= ill_n;
      end
      scan    <= scan_n;
      j       <= j_n;
      acc     <= acc_n;
      is_cpop <= is_cpop_n;
   end

endmodule

// File: tb/tb_bitmanip_seq.sv
// -----------------------------------------------------------------------------
// tb_bitmanip_seq
//
// Scoreboard bench for bitmanip_seq. The stimulus side pushes the expected
// result, illegal flag and latency when a request is accepted; a monitor pops
// and compares whenever the DUT presents a response, and checks that a held
// response stays stable under backpressure.
// -----------------------------------------------------------------------------
module tb_bitmanip_seq;

   localparam int CW = 8;
   localparam int N  = 32 / CW;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_illegal;
   logic        busy;

   bitmanip_seq #(.CHUNK_WIDTH(CW)) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_illegal (resp_illegal),
      .busy         (busy)
   );

   typedef struct {
      logic [31:0] data;
      logic        ill;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   exp_t e;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit rr_force;
   bit rr_val;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Latency of clz/ctz from the count: the chunk holding the first 1 is
   // number z/CW + 1, and the response follows one cycle later.
   function automatic int cnt_lat(input int z);
      if (z >= 32) return N + 1;
      return z / CW + 2;
   endfunction

   function automatic int kl(input int l);
`ifdef BITMANIP_FASTCOUNT_EN
      return 1;
`else
      return l;
`endif
   endfunction

   // Reference model straight from the instruction definitions.
   function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ill, output int lat);
      int sh;
      int z;
      logic [31:0] t;
      logic signed [7:0]  b8;
      logic signed [15:0] h16;
      sh  = int'(b[4:0]);
      ill = 1'b0;
      lat = 1;
      r   = '0;
      t   = a;
      case (op)
         5'd0: r = a & ~b;
         5'd1: r = a | ~b;
         5'd2: r = ~(a ^ b);
         5'd3: begin
            z = 0;
            while (z < 32 && a[31-z] == 1'b0) z++;
            r = 32'(z); lat = cnt_lat(z);
         end
         5'd4: begin
            z = 0;
            while (z < 32 && a[z] == 1'b0) z++;
            r = 32'(z); lat = cnt_lat(z);
         end
         5'd5: begin r = 32'($countones(a)); lat = N + 1; end
         5'd6: r = ($signed(a) > $signed(b)) ? a : b;
         5'd7: r = (a > b) ? a : b;
         5'd8: r = ($signed(a) < $signed(b)) ? a : b;
         5'd9: r = (a < b) ? a : b;
         5'd10: for (int i = 0; i < 4; i++) r[8*i +: 8] = (a[8*i +: 8] != 0) ? 8'hFF : 8'h00;
         5'd11: for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*(3-i) +: 8];
         5'd12: begin repeat (sh) t = {t[30:0], t[31]}; r = t; end
         5'd13: begin repeat (sh) t = {t[0], t[31:1]}; r = t; end
         5'd14: begin r = a; r[sh] = 1'b1; end
         5'd15: begin r = a; r[sh] = 1'b0; end
         5'd16: begin r = a; r[sh] = ~a[sh]; end
         5'd17: r = 32'(a[sh]);
         5'd18: begin b8 = a[7:0]; r = b8; end
         5'd19: begin h16 = a[15:0]; r = h16; end
         5'd20: r = a & 32'h0000_FFFF;
         5'd21: r = b + a * 2;
         5'd22: r = b + a * 4;
         5'd23: r = b + a * 8;
         default: begin r = '0; ill = 1'b1; end
      endcase
      lat = kl(lat);
   endfunction

   // Present a request, wait (bounded) for acceptance and record what the
   // response must be.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] d, input logic ill, input int lat);
      int   w;
      exp_t x;
      @(posedge clock); #1;
      req_valid = 1'b1;
      req_op    = op;
      req_rs1   = a;
      req_rs2   = b;
      w = 0;
      forever begin
         @(negedge clock);
         if (req_ready) break;
         w++;
         if (w > 200) break;
      end
      if (w > 200) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed 0 for op %0d", op);
      end else begin
         x.data = d; x.ill = ill; x.acc = cyc + 1; x.lat = lat;
         sbq.push_back(x);
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      req_op    = 5'($urandom);
      req_rs1   = $urandom;
      req_rs2   = $urandom;
   endtask

   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] d;
      logic        ill;
      int          lat;
      model(op, a, b, d, ill, lat);
      issue(op, a, b, d, ill, lat);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'd1 << $urandom_range(0, 31);
         2:       return $urandom >> $urandom_range(0, 31);
         3:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // resp_ready driver: random backpressure unless forced.
   initial begin
      resp_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         resp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compare each new response, then check it is held stable.
   logic        seen = 1'b0;
   logic        hs_prev = 1'b0;
   logic [31:0] held_d;
   logic        held_i;

   always @(negedge clock) begin
      if (!reset) begin
         if (hs_prev) begin
            chk("after_hs_resp_valid", 32'(resp_valid), 32'd0);
            chk("after_hs_busy", 32'(busy), 32'd0);
            if (!flush) chk("after_hs_req_ready", 32'(req_ready), 32'd1);
         end
         hs_prev = 1'b0;
         if (resp_valid) begin
            if (!seen) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got data %h with no request outstanding", resp_data);
               end else begin
                  e = sbq.pop_front();
                  chk("resp_data", resp_data, e.data);
                  chk("resp_illegal", 32'(resp_illegal), 32'(e.ill));
                  chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               end
               seen   = 1'b1;
               held_d = resp_data;
               held_i = resp_illegal;
            end else begin
               chk("held_data", resp_data, held_d);
               chk("held_illegal", 32'(resp_illegal), 32'(held_i));
            end
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            chk("resp_busy", 32'(busy), 32'd1);
            if (resp_ready) begin
               hs_prev = 1'b1;
               seen    = 1'b0;
            end
         end else begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      req_valid = 1'b0;
      req_op    = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      rr_force  = 1'b1;
      rr_val    = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_data", resp_data, 32'd0);
      chk("reset_resp_illegal", 32'(resp_illegal), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);

      // Directed cases with fixed expected values.
      issue(5'd5,  32'hF0F0_000F, 32'd0,         32'd12,          1'b0, kl(5));
      issue(5'd3,  32'h0001_0000, 32'd0,         32'd15,          1'b0, kl(3));
      issue(5'd3,  32'h0000_0000, 32'd0,         32'd32,          1'b0, kl(5));
      issue(5'd4,  32'h8000_0000, 32'd0,         32'd31,          1'b0, kl(5));
      issue(5'd4,  32'h0000_0000, 32'd0,         32'd32,          1'b0, kl(5));
      issue(5'd13, 32'h8000_0001, 32'd1,         32'hC000_0000,   1'b0, 1);
      issue(5'd12, 32'h1234_5678, 32'd32,        32'h1234_5678,   1'b0, 1);
      issue(5'd8,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF,   1'b0, 1);
      issue(5'd9,  32'hFFFF_FFFF, 32'd1,         32'd1,           1'b0, 1);
      issue(5'd6,  32'h8000_0000, 32'd5,         32'd5,           1'b0, 1);
      issue(5'd7,  32'h8000_0000, 32'd5,         32'h8000_0000,   1'b0, 1);
      issue(5'd23, 32'd2,         32'd5,         32'd21,          1'b0, 1);
      issue(5'd10, 32'h0012_0000, 32'd0,         32'h00FF_0000,   1'b0, 1);
      issue(5'd11, 32'h1122_3344, 32'd0,         32'h4433_2211,   1'b0, 1);
      issue(5'd17, 32'h0000_0010, 32'd4,         32'd1,           1'b0, 1);
      issue(5'd18, 32'h0000_0080, 32'd0,         32'hFFFF_FF80,   1'b0, 1);
      issue(5'd25, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0,           1'b1, 1);
      issue(5'd0,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF000_F000,   1'b0, 1);

      // Backpressure: hold resp_ready low while the response waits.
      rr_val = 1'b0;
      send(5'd2, 32'hA5A5_0000, 32'h0F0F_0F0F);
      repeat (4) @(negedge clock);
      rr_val = 1'b1;
      repeat (3) @(negedge clock);

`ifndef BITMANIP_FASTCOUNT_EN
      // Flush in the second COUNT cycle of a cpop, with a request waiting.
      send(5'd5, 32'hFFFF_FFFF, 32'd0);
      @(posedge clock); #1;
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = 5'd0;
      req_rs1   = 32'hFFFF_0000;
      req_rs2   = 32'h00FF_00FF;
      @(negedge clock);
      chk("flush_req_ready", 32'(req_ready), 32'd0);
      chk("flush_busy", 32'(busy), 32'd1);
      sbq.delete();
      @(posedge clock); #1;
      flush = 1'b0;
      @(negedge clock);
      chk("post_flush_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_flush_req_ready", 32'(req_ready), 32'd1);
      e.data = 32'hFF00_0000; e.ill = 1'b0; e.acc = cyc + 1; e.lat = 1;
      sbq.push_back(e);
      @(posedge clock); #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clock);

      // Reset in the second COUNT cycle, previous resp_data non-zero.
      send(5'd5, 32'h0000_00FF, 32'd0);
      @(posedge clock); #1;
      reset     = 1'b1;
      req_valid = 1'b1;
      req_op    = 5'd1;
      @(posedge clock); #1;
      reset     = 1'b0;
      req_valid = 1'b0;
      sbq.delete();
      @(negedge clock);
      chk("midop_reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("midop_reset_resp_data", resp_data, 32'd0);
      chk("midop_reset_resp_illegal", 32'(resp_illegal), 32'd0);
      chk("midop_reset_busy", 32'(busy), 32'd0);
      chk("midop_reset_req_ready", 32'(req_ready), 32'd1);
`endif

      // Randomized ops under random backpressure.
      rr_force = 1'b0;
      for (int i = 0; i < 200; i++) begin
         logic [4:0] op;
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
         send(op, rnd_opnd(), rnd_opnd());
      end

      // Drain outstanding responses (bounded).
      rr_force = 1'b1;
      rr_val   = 1'b1;
      for (int w = 0; w < 100; w++) begin
         @(negedge clock);
         if (sbq.size() == 0 && !resp_valid) break;
      end
      chk("drain_outstanding", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
